// File: rtl/fetch_decode_stage_register.sv
// F/D and D/X pipeline latches with load-use stall, branch squash
// and saturating stall/flush event counters.
module fetch_decode_stage_register #(
  parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0000,
  parameter int          COUNTER_WIDTH   = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [31:0]              fetch_instruction,
  input  logic [31:0]              fetch_pc,
  input  logic                     hazard_detected,
  input  logic                     branch_taken,
  output logic [31:0]              decode_instruction,
  output logic [31:0]              decode_pc,
  output logic                     decode_valid,
  output logic [31:0]              execute_instruction,
  output logic [31:0]              execute_pc,
  output logic                     execute_valid,
  output logic                     pc_write_enable,
  output logic [COUNTER_WIDTH-1:0] stall_count,
  output logic [COUNTER_WIDTH-1:0] flush_count
);

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        valid;
  } latch_t;

  localparam latch_t BUBBLE = '{
    ir:    NOP_INSTRUCTION,
    pc:    32'h0,
    valid: 1'b0
  };

  localparam logic [COUNTER_WIDTH-1:0] CMAX =
    {COUNTER_WIDTH{1'b1}};

  latch_t r_fd;
  latch_t r_dx;
  logic [COUNTER_WIDTH-1:0] r_stall_cnt;
  logic [COUNTER_WIDTH-1:0] r_flush_cnt;

  logic w_flush;
  logic w_stall;

  // a hazard against an empty F/D slot is meaningless
  assign w_flush = branch_taken;
  assign w_stall = hazard_detected & r_fd.valid & ~branch_taken;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fd <= BUBBLE;
      r_dx <= BUBBLE;
    end else begin
      unique case (1'b1)
        w_flush: begin
          r_fd <= BUBBLE;
          r_dx <= BUBBLE;
        end
        w_stall: begin
          r_fd <= r_fd;
          r_dx <= BUBBLE;
        end
        default: begin
          r_fd.ir    <= fetch_instruction;
          r_fd.pc    <= fetch_pc;
          r_fd.valid <= 1'b1;
          r_dx       <= r_fd;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_flush && r_flush_cnt != CMAX)
        r_flush_cnt <= r_flush_cnt + 1'b1;
      if (w_stall && r_stall_cnt != CMAX)
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign pc_write_enable     = ~w_stall;
  assign decode_instruction  = r_fd.ir;
  assign decode_pc           = r_fd.pc;
  assign decode_valid        = r_fd.valid;
  assign execute_instruction = r_dx.ir;
  assign execute_pc          = r_dx.pc;
  assign execute_valid       = r_dx.valid;
  assign stall_count         = r_stall_cnt;
  assign flush_count         = r_flush_cnt;

endmodule

// File: tb/tb_fetch_decode_stage_register.sv
// Directed-vector bench with expected-response queues and
// independent monitors for registered and combinational outputs.
module tb_fetch_decode_stage_register;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] fetch_instruction = 32'h0;
  logic [31:0] fetch_pc = 32'h0;
  logic        hazard_detected = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] decode_instruction;
  logic [31:0] decode_pc;
  logic        decode_valid;
  logic [31:0] execute_instruction;
  logic [31:0] execute_pc;
  logic        execute_valid;
  logic        pc_write_enable;
  logic [3:0]  stall_count;
  logic [3:0]  flush_count;

  fetch_decode_stage_register #(
    .NOP_INSTRUCTION (32'h0000_0000),
    .COUNTER_WIDTH   (4)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .fetch_instruction   (fetch_instruction),
    .fetch_pc            (fetch_pc),
    .hazard_detected     (hazard_detected),
    .branch_taken        (branch_taken),
    .decode_instruction  (decode_instruction),
    .decode_pc           (decode_pc),
    .decode_valid        (decode_valid),
    .execute_instruction (execute_instruction),
    .execute_pc          (execute_pc),
    .execute_valid       (execute_valid),
    .pc_write_enable     (pc_write_enable),
    .stall_count         (stall_count),
    .flush_count         (flush_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] dir;
    logic [31:0] dpc;
    logic        dv;
    logic [31:0] xir;
    logic [31:0] xpc;
    logic        xv;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;

  exp_t exp_q[$];
  logic pwe_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  function automatic exp_t mk(
    input logic [31:0] dir, input logic [31:0] dpc,
    input logic dv,
    input logic [31:0] xir, input logic [31:0] xpc,
    input logic xv,
    input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    e.dir = dir; e.dpc = dpc; e.dv = dv;
    e.xir = xir; e.xpc = xpc; e.xv = xv;
    e.sc = sc;   e.fc = fc;
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h",
               nm, cyc, act, req);
    end
  endtask

  task automatic step(
    input logic rn, input logic haz, input logic br,
    input logic [31:0] fi, input logic [31:0] fp,
    input logic pwe, input exp_t e);
    @(negedge clock);
    reset_n = rn;
    hazard_detected = haz;
    branch_taken = br;
    fetch_instruction = fi;
    fetch_pc = fp;
    pwe_q.push_back(pwe);
    exp_q.push_back(e);
  endtask

  // combinational output, sampled mid-cycle after inputs settle
  initial forever begin
    @(negedge clock);
    #2;
    if (pwe_q.size() != 0) begin
      logic p;
      p = pwe_q.pop_front();
      chk("pc_write_enable", {31'b0, pc_write_enable},
          {31'b0, p});
    end
  end

  // registered outputs, sampled just after the active edge
  initial forever begin
    @(posedge clock);
    #1;
    cyc++;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("decode_instruction", decode_instruction, e.dir);
      chk("decode_pc", decode_pc, e.dpc);
      chk("decode_valid", {31'b0, decode_valid},
          {31'b0, e.dv});
      chk("execute_instruction", execute_instruction, e.xir);
      chk("execute_pc", execute_pc, e.xpc);
      chk("execute_valid", {31'b0, execute_valid},
          {31'b0, e.xv});
      chk("stall_count", {28'b0, stall_count},
          {28'b0, e.sc});
      chk("flush_count", {28'b0, flush_count},
          {28'b0, e.fc});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] W0   = 32'h1234_5678;
  localparam logic [31:0] WA   = 32'h1111_1111;
  localparam logic [31:0] WB   = 32'h2222_2222;
  localparam logic [31:0] WC   = 32'h3333_3333;
  localparam logic [31:0] LD   = 32'h4040_0000;
  localparam logic [31:0] ADD  = 32'h0882_0000;
  localparam logic [31:0] W5   = 32'h5555_5555;
  localparam logic [31:0] W6   = 32'h6666_6666;
  localparam logic [31:0] W7   = 32'h7777_7777;
  localparam logic [31:0] W8   = 32'h8888_8888;
  localparam logic [31:0] W9   = 32'h9999_9999;
  localparam logic [31:0] WX   = 32'hAAAA_AAAA;

  initial begin
    // reset held two cycles
    step(0, 0, 0, W0, 32'h100, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    step(0, 0, 0, W0, 32'h100, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    // release with hazard on an invalid F/D entry: ignored
    step(1, 1, 0, W0, 32'h100, 1,
         mk(W0, 32'h100, 1, 0, 0, 0, 0, 0));
    // advance stream
    step(1, 0, 0, WA, 32'h0, 1,
         mk(WA, 32'h0, 1, W0, 32'h100, 1, 0, 0));
    step(1, 0, 0, WB, 32'h4, 1,
         mk(WB, 32'h4, 1, WA, 32'h0, 1, 0, 0));
    step(1, 0, 0, WC, 32'h8, 1,
         mk(WC, 32'h8, 1, WB, 32'h4, 1, 0, 0));
    // load then dependent add
    step(1, 0, 0, LD, 32'hC, 1,
         mk(LD, 32'hC, 1, WC, 32'h8, 1, 0, 0));
    step(1, 0, 0, ADD, 32'h10, 1,
         mk(ADD, 32'h10, 1, LD, 32'hC, 1, 0, 0));
    // load-use stall: F/D holds, bubble into D/X
    step(1, 1, 0, W5, 32'h14, 0,
         mk(ADD, 32'h10, 1, 0, 0, 0, 1, 0));
    step(1, 0, 0, W5, 32'h14, 1,
         mk(W5, 32'h14, 1, ADD, 32'h10, 1, 1, 0));
    // flush beats stall
    step(1, 1, 1, W6, 32'h18, 1,
         mk(0, 0, 0, 0, 0, 0, 1, 1));
    step(1, 0, 0, W7, 32'h40, 1,
         mk(W7, 32'h40, 1, 0, 0, 0, 1, 1));
    step(1, 0, 0, W8, 32'h44, 1,
         mk(W8, 32'h44, 1, W7, 32'h40, 1, 1, 1));
    // 20 stalled cycles: counter saturates at 15
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] s;
      s = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
      step(1, 1, 0, W9, 32'h48, 0,
           mk(W8, 32'h44, 1, 0, 0, 0, s, 1));
    end
    // reset while still stalling
    step(0, 1, 0, W9, 32'h48, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, W9, 32'h48, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 0, WX, 32'h50, 1,
         mk(WX, 32'h50, 1, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || pwe_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0",
               exp_q.size(), pwe_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stage_register.md
# fetch_decode_stage_register

Holds the pipeline state between fetch and execute: the F/D latch and the D/X latch. It feeds the instruction words that `hazard_detection_unit` compares, and acts on that unit's `hazard_detected` output. On a load-use hazard it freezes F/D, gates the PC, and injects a bubble into D/X. On a taken branch it squashes both latches. Saturating counters report stalls and flushes for performance monitoring.

## Interface
Parameters:
- `NOP_INSTRUCTION`, 32'h00000000, bubble encoding written into squashed latches
- `COUNTER_WIDTH`, 16, width of the stall and flush counters

Ports:
- `clock`  input  1  the single clock; all state updates on its rising edge
- `reset_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clock`
- `fetch_instruction`  input  32  instruction from instruction memory
- `fetch_pc`  input  32  PC of `fetch_instruction`
- `hazard_detected`  input  1  load-use stall request from `hazard_detection_unit`
- `branch_taken`  input  1  taken branch resolved in execute; squash younger instructions
- `decode_instruction`  output  32  F/D.IR, goes to `hazard_detection_unit` and decode
- `decode_pc`  output  32  F/D.PC
- `decode_valid`  output  1  F/D holds a real instruction
- `execute_instruction`  output  32  D/X.IR, goes to `hazard_detection_unit` and execute
- `execute_pc`  output  32  D/X.PC
- `execute_valid`  output  1  D/X holds a real instruction
- `pc_write_enable`  output  1  combinational; 0 freezes the fetch PC
- `stall_count`  output  COUNTER_WIDTH  number of stall cycles, saturating
- `flush_count`  output  COUNTER_WIDTH  number of flush cycles, saturating

## Operation
- Instruction fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12]. LOAD = 5'b01000, STORE = 5'b00111. This block does not decode fields. It only moves words between latches.
- Internal `stall = hazard_detected & decode_valid & ~branch_taken`. A hazard flagged against an invalid F/D entry is ignored.
- Per-cycle priority when `reset_n` = 1 is flush > stall > advance:
  - **Flush** (`branch_taken` = 1):
    - F/D.IR and D/X.IR ← `NOP_INSTRUCTION`.
    - Both valid bits ← 0.
    - Both PC latches ← 0.
    - `flush_count` += 1.
  - **Stall**:
    - F/D (IR, PC, valid) holds its value.
    - D/X.IR ← `NOP_INSTRUCTION`, D/X.PC ← 0, `execute_valid` ← 0.
    - `stall_count` += 1.
  - **Advance**:
    - F/D ← {`fetch_instruction`, `fetch_pc`, 1}.
    - D/X ← F/D (IR, PC, valid).
- `pc_write_enable = ~stall`. It is combinational from the inputs and current state, and is 1 during a flush so that fetch can redirect.
- Counters:
  - Saturate at 2^COUNTER_WIDTH−1 and never wrap.
  - Cleared only by reset.
  - If flush and hazard occur in the same cycle, only `flush_count` increments.

## Timing
- Reset (`reset_n` = 0 at an edge):
  - IR latches = `NOP_INSTRUCTION`.
  - PC latches = 0.
  - Valid bits = 0.
  - Both counters = 0.
  - `pc_write_enable` = 1 after reset, since `decode_valid` = 0.
- Reset mid-stall or mid-flush overrides everything at that edge.
- Latency: fetch → decode is 1 cycle, and decode → execute is 1 cycle.
- A load-use hazard costs exactly one stall cycle:
  - Cycle N: `hazard_detected` = 1. The bubble is written into D/X at the end of cycle N.
  - Cycle N+1: `execute_instruction` is NOP (opcode ≠ LOAD), so `hazard_detected` falls and F/D advances.
- `hazard_detected` is combinational from this block's registered outputs. No combinational loop exists, because `pc_write_enable` does not feed back into `hazard_detected`.
- During a stall, `fetch_instruction` and `fetch_pc` are ignored. Fetch re-presents the same word the next cycle because the PC was frozen.
- A `hazard_detected` that stays asserted indefinitely stalls indefinitely. Each stalled cycle counts.

## Test plan
- **Reset:**
  - Stimulus: hold `reset_n` = 0 for 2 cycles with `fetch_instruction` = 32'h12345678.
  - Required: all IR outputs = 0, all valid bits = 0, counters = 0, `pc_write_enable` = 1. One cycle after release, `decode_instruction` = 32'h12345678 with `decode_pc` = `fetch_pc`.
- **Advance:**
  - Stimulus: stream words A, B, C at PCs 0, 4, 8 with no hazard or branch.
  - Required: each word appears at decode 1 cycle after fetch and at execute 2 cycles after fetch. Valid bits = 1. Counters stay 0.
- **Load-use stall:**
  - Stimulus: D/X = LOAD (32'h40400000, rd = 1), F/D = ADD using rs = 1; assert `hazard_detected` for 1 cycle.
  - Required: `pc_write_enable` = 0 that cycle. Next cycle F/D still holds the ADD, `execute_instruction` = 0, `execute_valid` = 0, `stall_count` = 1. The cycle after that, the ADD is in D/X.
- **Flush beats stall:**
  - Stimulus: assert `branch_taken` and `hazard_detected` in the same cycle.
  - Required: both latches become NOP with valid = 0. `flush_count` = 1, `stall_count` unchanged, `pc_write_enable` = 1.
- **Hazard on an invalid entry:**
  - Stimulus: right after reset (`decode_valid` = 0), assert `hazard_detected`.
  - Required: no stall, `pc_write_enable` = 1, F/D loads the fetched word.
- **Saturation and reset mid-stall:**
  - Stimulus: with COUNTER_WIDTH = 4, hold the stall condition for 20 cycles, then pull `reset_n` low while still stalling.
  - Required: `stall_count` reaches 15 and holds there. The reset edge clears the counter and the latches.
